// File: rtl/dac_serializer.sv
// I2S DAC serializer: latches a stereo pair on each left-channel LRCK edge and shifts it out
// MSB first with the one-bit I2S delay. Optional mono downmix when DAC_MONO_MIX_EN is defined.
module dac_serializer (
   input  logic        BCLK,
   input  logic        ADCLRCK,
   input  logic        DACLRCK,
   input  logic [15:0] leftSampleIn,
   input  logic [15:0] rightSampleIn,
   output logic        DACDAT,
   output logic        sample_latched,
   output logic        short_frame
);

   typedef enum logic [1:0] {StIdle, StShift, StPad} state_e;

   state_e      state;
   logic        lrck_d;
   logic [15:0] hold_r;
   logic [14:0] shift_reg;
   logic [3:0]  bit_cnt;
   logic        left_edge;
   logic        right_edge;
   logic [15:0] load_l;
   logic [15:0] load_r;

   assign left_edge  = lrck_d & ~DACLRCK;
   assign right_edge = ~lrck_d & DACLRCK;

`ifdef DAC_MONO_MIX_EN
   // 17-bit signed sum, arithmetic shift floors toward negative infinity
   assign load_l = 16'(($signed({leftSampleIn[15], leftSampleIn})
                      + $signed({rightSampleIn[15], rightSampleIn})) >>> 1);
   assign load_r = load_l;
`else
   assign load_l = leftSampleIn;
   assign load_r = rightSampleIn;
`endif

   // The left word goes straight into the shifter; only the right word must be held.
   always_ff @(negedge BCLK or posedge ADCLRCK) begin
      if (ADCLRCK) begin
         state          <= StIdle;
         lrck_d         <= 1'b0;
         hold_r         <= 16'h0000;
         shift_reg      <= 15'h0000;
         bit_cnt        <= 4'd0;
         DACDAT         <= 1'b0;
         sample_latched <= 1'b0;
         short_frame    <= 1'b0;
      end else begin
         lrck_d         <= DACLRCK;
         sample_latched <= 1'b0;
         if (left_edge || (right_edge && state != StIdle)) begin
            if (state == StShift && bit_cnt != 4'd0) begin
               short_frame <= 1'b1;
            end
            bit_cnt <= 4'd15;
            state   <= StShift;
            if (left_edge) begin
               hold_r         <= load_r;
               sample_latched <= 1'b1;
               DACDAT         <= load_l[15];
               shift_reg      <= load_l[14:0];
            end else begin
               DACDAT    <= hold_r[15];
               shift_reg <= hold_r[14:0];
            end
         end else begin
            case (state)
               StShift: begin
                  if (bit_cnt == 4'd0) begin
                     state  <= StPad;
                     DACDAT <= 1'b0;
                  end else begin
                     DACDAT    <= shift_reg[14];
                     shift_reg <= {shift_reg[13:0], 1'b0};
                     bit_cnt   <= bit_cnt - 4'd1;
                  end
               end
               StPad:   DACDAT <= 1'b0;
               StIdle:  DACDAT <= 1'b0;
               default: begin
                  state  <= StIdle;
                  DACDAT <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
